readfromdram: RTL and testbench

//  DDR3 stream reader: Avalon-MM read master that fetches stream_length 16-bit samples

---
 rtl/readfromdram_if.sv | 36 +++
 rtl/readfromdram.sv | 168 ++++++++++++++++
 tb/tb_readfromdram.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/readfromdram_if.sv
// readfromdram bus bundle: DDR3 Avalon-MM read port, CSR slave port, sample stream, status.
// Latency: none, this is wiring only.
// Backpressure: carries ddr_waitrequest (DDR stall) and ready (stream sink stall).
// Modports: master = reader side (drives ddr_addr/ddr_read, csr_readdata, d_out/v,
//           busy/done); slave = environment side (DDR controller, CPU, sink).
interface readfromdram_if #(
    parameter int DATA_W = 16
);
    logic              ddr_waitrequest;
    logic [31:0]       ddr_addr;
    logic              ddr_read;
    logic [DATA_W-1:0] ddr_readdata;
    logic              ddr_readdatavalid;
    logic [1:0]        csr_addr;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;
    logic [DATA_W-1:0] d_out;
    logic              v;
    logic              ready;
    logic              busy;
    logic              done;

    modport master (
        input  ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
        input  csr_addr, csr_read, csr_write, csr_writedata, ready,
        output ddr_addr, ddr_read, csr_readdata, d_out, v, busy, done
    );

    modport slave (
        output ddr_waitrequest, ddr_readdata, ddr_readdatavalid,
        output csr_addr, csr_read, csr_write, csr_writedata, ready,
        input  ddr_addr, ddr_read, csr_readdata, d_out, v, busy, done
    );
endinterface

// File: rtl/readfromdram.sv
// DDR3 stream reader: Avalon-MM read master fetching stream_length samples (addr_init, stride addr_step) into a show-ahead FIFO.
// Latency: readdatavalid to v is 1 cycle; CSR read data 1 cycle after csr_read.
// Backpressure: reads are issued only while outstanding + buffered < FIFO_DEPTH, so a stalled sink throttles DDR requests.
// Ports: clk, rst (synchronous, active-high), bus (readfromdram_if.master: ddr_*, csr_*, d_out/v/ready, busy/done).
// CSR: 0 addr_init, 1 stream_length, 2 addr_step, 3 write=start / read={30'b0,done,busy}.
// Option: READFROMDRAM_LOOP_EN enables circular playback (CSR3 data[0]=1 start, 0 stop).
module readfromdram #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    readfromdram_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_init_q, addr_init_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       step_q, step_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       issued_q, issued_d;
    logic [31:0]       csr_rdata_q, csr_rdata_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic              stop_q, stop_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic busy, done, credit, rd_req, accept, push, pop, last_acc;
    logic start_wr, stop_wr;

    assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

`ifdef READFROMDRAM_LOOP_EN
    assign start_wr = bus.csr_write && (bus.csr_addr == 2'd3) && bus.csr_writedata[0];
    assign stop_wr  = bus.csr_write && (bus.csr_addr == 2'd3) && !bus.csr_writedata[0];
`else
    assign start_wr = bus.csr_write && (bus.csr_addr == 2'd3);
    assign stop_wr  = 1'b0;
`endif

    // Every in-flight read owns a FIFO slot, so the buffer can never overflow.
    assign credit   = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_V;
    assign rd_req   = (state_q == S_ISSUE) && credit;
    assign accept   = rd_req && !bus.ddr_waitrequest;
    // Responses with nothing outstanding are leftovers from an aborted transfer.
    assign push     = bus.ddr_readdatavalid && (outst_q != '0);
    assign pop      = (cnt_q != '0) && bus.ready;
    assign last_acc = accept && (issued_q == len_q - 32'd1);

    always_comb begin
        state_d     = state_q;
        addr_init_d = addr_init_q;
        len_d       = len_q;
        step_d      = step_q;
        addr_d      = addr_q;
        issued_d    = issued_q;
        stop_d      = stop_q;
        csr_rdata_d = csr_rdata_q;
        outst_d     = outst_q + CW'(accept) - CW'(push);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);

        if (bus.csr_write && !busy) begin
            case (bus.csr_addr)
                2'd0:    addr_init_d = bus.csr_writedata;
                2'd1:    len_d       = bus.csr_writedata;
                2'd2:    step_d      = bus.csr_writedata;
                default: ;
            endcase
        end

        if (bus.csr_read) begin
            case (bus.csr_addr)
                2'd0:    csr_rdata_d = addr_init_q;
                2'd1:    csr_rdata_d = len_q;
                2'd2:    csr_rdata_d = step_q;
                2'd3:    csr_rdata_d = {30'b0, done, busy};
                default: csr_rdata_d = 32'hdeadbeef;
            endcase
        end

        if (accept) begin
            addr_d   = addr_q + step_q;
            issued_d = issued_q + 32'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_wr) begin
                    addr_d   = addr_init_q;
                    issued_d = '0;
                    stop_d   = 1'b0;
                    state_d  = (len_q == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (stop_wr) stop_d = 1'b1;
                if (last_acc) begin
`ifdef READFROMDRAM_LOOP_EN
                    if (stop_q || stop_wr) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d   = addr_init_q;
                        issued_d = '0;
                    end
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            // All issued reads answered and buffer drained; outstanding==0 is
            // equivalent to received==length since nothing is dropped mid-transfer.
            S_DRAIN: begin
                if ((outst_q == '0) && (cnt_q == '0)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_init_q <= '0;
            len_q       <= '0;
            step_q      <= 32'd1;
            addr_q      <= '0;
            issued_q    <= '0;
            stop_q      <= 1'b0;
            csr_rdata_q <= '0;
            outst_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_init_q <= addr_init_d;
            len_q       <= len_d;
            step_q      <= step_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            stop_q      <= stop_d;
            csr_rdata_q <= csr_rdata_d;
            outst_q     <= outst_d;
            cnt_q       <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= bus.ddr_readdata;
    end

    assign bus.ddr_addr     = addr_q;
    assign bus.ddr_read     = rd_req;
    assign bus.csr_readdata = csr_rdata_q;
    assign bus.v            = (cnt_q != '0);
    // Gate with v so the stream reads zero while empty (memory is not reset).
    assign bus.d_out        = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.busy         = busy;
    assign bus.done         = done;
endmodule

// File: tb/tb_readfromdram.sv
module tb_readfromdram;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    readfromdram_if #(.DATA_W(16)) bus ();
    readfromdram #(.DATA_W(16), .FIFO_DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_addr[$];
    logic [15:0] exp_dat[$];
    typedef struct {int due; logic [15:0] dat;} rsp_t;
    rsp_t pend[$];

    int cyc = 0, acc_cnt = 0, popped = 0, stall_cycles = 0;
    int stall_idx = -1, stall_left = 0;
    bit stalling = 0;
    logic [31:0] stall_addr = '0;

    function automatic logic [15:0] mem_fn(input logic [31:0] a);
        return a[15:0] ^ 16'h5a3c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_addr = a; bus.csr_writedata = d; bus.csr_write = 1'b1;
        tick();
        bus.csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_addr = a; bus.csr_read = 1'b1;
        tick();
        bus.csr_read = 1'b0;
        d = bus.csr_readdata;
    endtask

    task automatic start_xfer(input logic [31:0] init, input logic [31:0] len, input logic [31:0] step);
        csr_wr(2'd0, init);
        csr_wr(2'd1, len);
        csr_wr(2'd2, step);
        for (int i = 0; i < int'(len); i++) begin
            exp_addr.push_back(init + 32'(i) * step);
            exp_dat.push_back(mem_fn(init + 32'(i) * step));
        end
        csr_wr(2'd3, 32'd1);
`ifdef READFROMDRAM_LOOP_EN
        csr_wr(2'd3, 32'd0);
`endif
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin tick(); n++; end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    // DDR model: fixed-latency responses, optional waitrequest burst on one request.
    initial begin
        bus.ddr_waitrequest = 1'b0;
        bus.ddr_readdatavalid = 1'b0;
        bus.ddr_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.ddr_readdatavalid = 1'b0;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                bus.ddr_readdatavalid = 1'b1;
                bus.ddr_readdata = pend[0].dat;
                void'(pend.pop_front());
            end
            if (stalling) begin
                chk("stall_read_held", 32'(bus.ddr_read), 32'd1);
                chk("stall_addr_held", bus.ddr_addr, stall_addr);
            end
            if (stall_left > 0 && bus.ddr_read === 1'b1 && acc_cnt == stall_idx) begin
                bus.ddr_waitrequest = 1'b1;
                if (!stalling) stall_addr = bus.ddr_addr;
                stalling = 1'b1;
                stall_left--;
                stall_cycles++;
            end else begin
                bus.ddr_waitrequest = 1'b0;
                stalling = 1'b0;
                if (bus.ddr_read === 1'b1) begin
                    acc_cnt++;
                    chk("req_expected", 32'(exp_addr.size() != 0), 32'd1);
                    if (exp_addr.size() != 0) chk("req_addr", bus.ddr_addr, exp_addr.pop_front());
                    pend.push_back('{due: cyc + LAT, dat: mem_fn(bus.ddr_addr)});
                end
            end
        end
    end

    // Stream scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.v === 1'b1 && bus.ready === 1'b1) begin
                popped++;
                chk("sample_expected", 32'(exp_dat.size() != 0), 32'd1);
                if (exp_dat.size() != 0) chk("sample", 32'(bus.d_out), 32'(exp_dat.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int base, n;
        rst = 1'b1;
        bus.csr_addr = '0; bus.csr_read = 1'b0; bus.csr_write = 1'b0; bus.csr_writedata = '0;
        bus.ready = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_ddr_read", 32'(bus.ddr_read), 32'd0);
        chk("rst_ddr_addr", bus.ddr_addr, 32'd0);
        chk("rst_csr_rdata", bus.csr_readdata, 32'd0);
        chk("rst_d_out", 32'(bus.d_out), 32'd0);
        chk("rst_v", 32'(bus.v), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        csr_rd(2'd0, rd); chk("rst_addr_init", rd, 32'd0);
        csr_rd(2'd1, rd); chk("rst_len", rd, 32'd0);
        csr_rd(2'd2, rd); chk("rst_step", rd, 32'd1);
        csr_rd(2'd3, rd); chk("rst_status", rd, 32'd0);

        // Zero-length start: DONE next cycle, no requests
        csr_wr(2'd3, 32'd1);
        chk("len0_done", 32'(bus.done), 32'd1);
        chk("len0_busy", 32'(bus.busy), 32'd0);
        tick(4);
        chk("len0_no_req", 32'(acc_cnt), 32'd0);

        // Basic transfer with stride
        bus.ready = 1'b1;
        start_xfer(32'h100, 32'd4, 32'd2);
        wait_done("t1_done", 100);
        csr_rd(2'd3, rd); chk("t1_status", rd, 32'd2);
        chk("t1_req_count", 32'(acc_cnt), 32'd4);
        chk("t1_addr_left", 32'(exp_addr.size()), 32'd0);
        chk("t1_dat_left", 32'(exp_dat.size()), 32'd0);

        // Waitrequest burst on the second request
        base = acc_cnt;
        stall_idx = acc_cnt + 1; stall_left = 3;
        start_xfer(32'h200, 32'd6, 32'd3);
        wait_done("t2_done", 100);
        chk("t2_stall_cycles", 32'(stall_cycles), 32'd3);
        chk("t2_req_count", 32'(acc_cnt - base), 32'd6);
        chk("t2_dat_left", 32'(exp_dat.size()), 32'd0);

        // Sink stalled: credit limits reads to FIFO_DEPTH
        bus.ready = 1'b0;
        base = acc_cnt;
        start_xfer(32'h1000, 32'd40, 32'd1);
        tick(60);
        chk("t3_credit_reqs", 32'(acc_cnt - base), 32'd16);
        chk("t3_read_stalled", 32'(bus.ddr_read), 32'd0);
        chk("t3_v", 32'(bus.v), 32'd1);
        chk("t3_head_held", 32'(bus.d_out), 32'(mem_fn(32'h1000)));
        chk("t3_busy", 32'(bus.busy), 32'd1);
        bus.ready = 1'b1;
        wait_done("t3_done", 400);
        chk("t3_req_count", 32'(acc_cnt - base), 32'd40);
        chk("t3_dat_left", 32'(exp_dat.size()), 32'd0);

        // Start and config writes while busy are ignored
        base = acc_cnt;
        start_xfer(32'h300, 32'd8, 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd1);
        csr_wr(2'd0, 32'h500);
        csr_wr(2'd3, 32'd1);
        csr_rd(2'd0, rd); chk("t4_init_busy", rd, 32'h300);
        wait_done("t4_done", 100);
        chk("t4_req_count", 32'(acc_cnt - base), 32'd8);
        chk("t4_dat_left", 32'(exp_dat.size()), 32'd0);
        csr_rd(2'd0, rd); chk("t4_init_after", rd, 32'h300);

        // Reset mid-transfer
        base = popped;
        start_xfer(32'h400, 32'd10, 32'd1);
        n = 0;
        while (popped - base < 5 && n < 100) begin tick(); n++; end
        chk("t5_reached_5", 32'(popped - base >= 5), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_addr.delete();
        exp_dat.delete();
        chk("t5_ddr_read", 32'(bus.ddr_read), 32'd0);
        chk("t5_ddr_addr", bus.ddr_addr, 32'd0);
        chk("t5_v", 32'(bus.v), 32'd0);
        chk("t5_d_out", 32'(bus.d_out), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_csr_rdata", bus.csr_readdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_v_stays_low", 32'(bus.v), 32'd0);
        end
        csr_rd(2'd2, rd); chk("t5_step_reset", rd, 32'd1);

`ifdef READFROMDRAM_LOOP_EN
        // Circular playback, stop mid second pass
        base = acc_cnt;
        csr_wr(2'd0, 32'd0);
        csr_wr(2'd1, 32'd3);
        csr_wr(2'd2, 32'd1);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                exp_addr.push_back(32'(i));
                exp_dat.push_back(mem_fn(32'(i)));
            end
        end
        stall_idx = base + 4; stall_left = 5;
        csr_wr(2'd3, 32'd1);
        n = 0;
        while (acc_cnt - base < 4 && n < 100) begin tick(); n++; end
        csr_wr(2'd3, 32'd0);
        wait_done("t6_done", 200);
        chk("t6_req_count", 32'(acc_cnt - base), 32'd6);
        chk("t6_dat_left", 32'(exp_dat.size()), 32'd0);
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
